pipeline_cpu_top: RTL and testbench
===================================

Name: pipeline_cpu_top

Overview:
- Top level of a 5-stage in-order RV64I-subset pipeline (IF, ID, EX, MEM, WB) with Harvard instruction and data memories.
- Self-contained: the only inputs are clock and reset. Programs and data are preloaded into the memory arrays by the environment via hierarchical access.
- Architectural state is inspected hierarchically by the bench.

Parameters:
- XLEN, 64, datapath and register width.
- IMEM_WORDS, 64, instruction memory depth in 32-bit words.
- DMEM_BYTES, 256, data memory depth in bytes.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.

Behaviour:
- Fixed instance/array names, required for hierarchical inspection:
  - PC: program counter register, output signal OUT [63:0].
  - INST_MEM: array memory[0:IMEM_WORDS-1] of 32 bits.
  - REGISTERS: array register_bank[0:31] of 64 bits.
  - DATA_MEM: array memory[0:DMEM_BYTES-1] of 8 bits.
- Reset, on a rising edge with rst=1:
  - PC.OUT=0.
  - All pipeline registers cleared to bubbles (no register or memory writes).
  - register_bank all 0.
  - INST_MEM and DATA_MEM contents are never touched by reset; they may be loaded while rst is high.
- Fetch:
  - Instruction = INST_MEM.memory[PC.OUT[63:2]].
  - PC advances by 4 each cycle unless stalled or redirected.
  - An index beyond the IMEM depth reads as 0, which decodes as a NOP.
- Supported instructions: add, sub, and, or, slt (R-type); addi (I); ld (I); sd (S); beq (B). Any other encoding is a NOP.
- Register file:
  - x0 reads as 0 and its writes are ignored.
  - Writes occur in WB on the rising edge; reads in ID see the same-cycle WB value (write-before-read bypass).
- Data memory:
  - ld/sd access 8 bytes at address rs1+imm, little-endian, so byte addr holds bits [7:0].
  - Read is combinational; write on the rising edge in MEM.
- Forwarding: EX operands are taken from EX/MEM, then MEM/WB (in that priority) when the destination register matches and is not x0.
- Load-use hazard: if the instruction in EX is ld and its rd equals rs1 or rs2 of the instruction in ID, stall PC and IF/ID for 1 cycle and insert a bubble into ID/EX.
- Branch:
  - beq resolves in EX with target PC+imm.
  - If taken, flush IF/ID and ID/EX (2-cycle penalty) and load the target into PC.
  - Simultaneous stall and taken branch: the flush wins.
- Latency: a result is visible in register_bank 5 cycles after its instruction is fetched.
- Arithmetic is 64-bit two's complement with wrap-around and no overflow trap.
- Immediates are sign-extended to 64 bits.

Decomposition:
- Shared package holds:
  - opcode constants: OP_R=0110011, OP_I=0010011, OP_LD=0000011, OP_SD=0100011, OP_BR=1100011.
  - ALU operation enum.
  - IF/ID, ID/EX, EX/MEM, MEM/WB pipeline-register structs.
- Natural sub-modules: an alu (64-bit, combinational), plus the named storage blocks (PC, REGISTERS, INST_MEM, DATA_MEM).
- Hazard/forwarding logic lives inline in the top.

Test Plan:
- Reset: hold rst=1 for 3 cycles -> PC.OUT=0, all register_bank=0, and preloaded DATA_MEM bytes are unchanged.
- Load/ALU/store with forwarding:
  - Setup: DATA_MEM[0..7]=0x0A, DATA_MEM[8..15]=0x14.
  - Program: ld x1,0(x0); ld x2,8(x0); add x3,x1,x2; sd x3,16(x0).
  - Expected: x3=0x1E, DATA_MEM[16..23]=0x1E little-endian, with a load-use stall before add.
- ALU chain with back-to-back dependencies: addi x1,x0,5; addi x2,x1,-7; sub x3,x1,x2; and x4,x3,x1 -> x2=0xFFFF_FFFF_FFFF_FFFE, x3=7, x4=5.
- Taken branch flush: addi x1,x0,1; beq x1,x1,+8; addi x2,x0,9; addi x3,x0,3 -> x2=0 (flushed), x3=3.
- Not-taken branch: beq x0,x1,+8 with x1=1 -> the next sequential instruction executes and PC advances by 4 with no flush.
- x0 protection: addi x0,x0,7 followed by add x5,x0,x0 -> register_bank[0]=0 and x5=0.

Source files
------------

// File: rtl/pipeline_cpu_top_pkg.sv
// Shared types and constants for the 5-stage RV64I-subset pipeline.
package pipeline_cpu_top_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned RIDX_W = 5;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
        logic [RIDX_W-1:0] rs1;
        logic [RIDX_W-1:0] rs2;
        logic [RIDX_W-1:0] rd;
        alu_op_e           alu_op;
        logic              use_imm;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   store_data;
        logic [RIDX_W-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0]   wb_data;
        logic [RIDX_W-1:0] rd;
        logic              reg_write;
    } mem_wb_t;

endpackage

// File: rtl/pipeline_cpu_top_alu.sv
// 64-bit combinational ALU.
module pipeline_cpu_top_alu
    import pipeline_cpu_top_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_e         op,
    output logic [XLEN-1:0] result_c
);

    // Operation select; slt is a signed compare.
    always_comb begin
        result_c = '0;
        case (op)
            ALU_ADD: result_c = a + b;
            ALU_SUB: result_c = a - b;
            ALU_AND: result_c = a & b;
            ALU_OR:  result_c = a | b;
            ALU_SLT: result_c = XLEN'($signed(a) < $signed(b));
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/pipeline_cpu_top_dmem.sv
// Byte-addressed data memory, 8-byte little-endian access.
module pipeline_cpu_top_dmem
    import pipeline_cpu_top_pkg::*;
#(
    parameter int unsigned DMEM_BYTES = 256
) (
    input  logic            clk,
    input  logic            we,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata_c
);

    localparam int unsigned AW = $clog2(DMEM_BYTES);

    logic [7:0] memory [0:DMEM_BYTES-1];

    // Combinational doubleword read; byte addr lands in bits [7:0].
    always_comb begin
        rdata_c = '0;
        for (int k = 0; k < 8; k++) begin
            rdata_c[8*k +: 8] = memory[AW'(addr + XLEN'(k))];
        end
    end

    // Doubleword store on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 8; k++) begin
                memory[AW'(addr + XLEN'(k))] <= wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/pipeline_cpu_top_imem.sv
// Instruction memory; words past the end read as 0 (a NOP).
module pipeline_cpu_top_imem
    import pipeline_cpu_top_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic [XLEN-3:0] word_addr,
    output logic [31:0]     inst_c
);

    localparam int unsigned AW = $clog2(IMEM_WORDS);

    logic [31:0] memory [0:IMEM_WORDS-1];

    // Asynchronous read with out-of-range guard.
    always_comb begin
        inst_c = '0;
        if (word_addr < (XLEN-2)'(IMEM_WORDS)) begin
            inst_c = memory[word_addr[AW-1:0]];
        end
    end

endmodule

// File: rtl/pipeline_cpu_top_pc.sv
// Program counter register.
module pipeline_cpu_top_pc
    import pipeline_cpu_top_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] OUT
);

    // Load the next fetch address unless held.
    always_ff @(posedge clk) begin
        if (rst) begin
            OUT <= '0;
        end else if (en) begin
            OUT <= next_pc;
        end
    end

endmodule

// File: rtl/pipeline_cpu_top_regfile.sv
// 32 x 64 register file with write-before-read bypass; x0 stays zero.
module pipeline_cpu_top_regfile
    import pipeline_cpu_top_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [RIDX_W-1:0] raddr1,
    input  logic [RIDX_W-1:0] raddr2,
    input  logic              we,
    input  logic [RIDX_W-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata1_c,
    output logic [XLEN-1:0]   rdata2_c
);

    logic [XLEN-1:0] register_bank [0:31];

    // Clear on reset, otherwise write from WB (never x0).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                register_bank[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            register_bank[waddr] <= wdata;
        end
    end

    // ID reads see a same-cycle WB write.
    always_comb begin
        rdata1_c = register_bank[raddr1];
        rdata2_c = register_bank[raddr2];
        if (we && (waddr != '0) && (waddr == raddr1)) rdata1_c = wdata;
        if (we && (waddr != '0) && (waddr == raddr2)) rdata2_c = wdata;
    end

endmodule

// File: rtl/pipeline_cpu_top.sv
// 5-stage in-order RV64I-subset pipeline with forwarding, load-use stall and EX-resolved beq.
module pipeline_cpu_top
    import pipeline_cpu_top_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned DMEM_BYTES = 256
) (
    input logic clk,
    input logic rst
);

    if_id_t  if_id,  if_id_next;
    id_ex_t  id_ex,  id_ex_next, dec;
    ex_mem_t ex_mem, ex_mem_next;
    mem_wb_t mem_wb, mem_wb_next;

    logic [XLEN-1:0]   pc, pc_next, branch_target;
    logic              pc_en, stall, taken;
    logic [31:0]       fetch_inst;
    logic [XLEN-1:0]   rs1_rdata, rs2_rdata, dmem_rdata;
    logic [XLEN-1:0]   fwd_a, fwd_b, alu_b, alu_result;
    logic [6:0]        opcode, funct7;
    logic [2:0]        funct3;
    logic [RIDX_W-1:0] id_rs1, id_rs2, id_rd;

    pipeline_cpu_top_pc PC (
        .clk(clk), .rst(rst), .en(pc_en), .next_pc(pc_next), .OUT(pc)
    );

    pipeline_cpu_top_imem #(.IMEM_WORDS(IMEM_WORDS)) INST_MEM (
        .word_addr(pc[XLEN-1:2]), .inst_c(fetch_inst)
    );

    pipeline_cpu_top_regfile REGISTERS (
        .clk(clk), .rst(rst),
        .raddr1(id_rs1), .raddr2(id_rs2),
        .we(mem_wb.reg_write), .waddr(mem_wb.rd), .wdata(mem_wb.wb_data),
        .rdata1_c(rs1_rdata), .rdata2_c(rs2_rdata)
    );

    pipeline_cpu_top_alu u_alu (
        .a(fwd_a), .b(alu_b), .op(id_ex.alu_op), .result_c(alu_result)
    );

    pipeline_cpu_top_dmem #(.DMEM_BYTES(DMEM_BYTES)) DATA_MEM (
        .clk(clk), .we(ex_mem.mem_write), .addr(ex_mem.alu_result),
        .wdata(ex_mem.store_data), .rdata_c(dmem_rdata)
    );

    assign opcode = if_id.inst[6:0];
    assign id_rd  = if_id.inst[11:7];
    assign funct3 = if_id.inst[14:12];
    assign id_rs1 = if_id.inst[19:15];
    assign id_rs2 = if_id.inst[24:20];
    assign funct7 = if_id.inst[31:25];

    // ID: decode into an ID/EX payload; unsupported encodings stay all-off (NOP).
    always_comb begin
        dec           = '0;
        dec.pc        = if_id.pc;
        dec.rs1       = id_rs1;
        dec.rs2       = id_rs2;
        dec.rd        = id_rd;
        dec.rs1_val   = rs1_rdata;
        dec.rs2_val   = rs2_rdata;
        dec.alu_op    = ALU_ADD;
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: dec.alu_op = ALU_ADD;
                    10'b0100000_000: dec.alu_op = ALU_SUB;
                    10'b0000000_111: dec.alu_op = ALU_AND;
                    10'b0000000_110: dec.alu_op = ALU_OR;
                    10'b0000000_010: dec.alu_op = ALU_SLT;
                    default:         dec.reg_write = 1'b0;
                endcase
            end
            OP_I: if (funct3 == 3'b000) begin
                dec.reg_write = 1'b1;
                dec.use_imm   = 1'b1;
                dec.imm       = {{(XLEN-12){if_id.inst[31]}}, if_id.inst[31:20]};
            end
            OP_LD: if (funct3 == 3'b011) begin
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.use_imm   = 1'b1;
                dec.imm       = {{(XLEN-12){if_id.inst[31]}}, if_id.inst[31:20]};
            end
            OP_SD: if (funct3 == 3'b011) begin
                dec.mem_write = 1'b1;
                dec.use_imm   = 1'b1;
                dec.imm       = {{(XLEN-12){if_id.inst[31]}}, if_id.inst[31:25], if_id.inst[11:7]};
            end
            OP_BR: if (funct3 == 3'b000) begin
                dec.branch = 1'b1;
                dec.imm    = {{(XLEN-12){if_id.inst[31]}}, if_id.inst[7], if_id.inst[30:25],
                              if_id.inst[11:8], 1'b0};
            end
            default: ;
        endcase
    end

    // Load-use hazard: load in EX feeding either source field in ID.
    assign stall = id_ex.mem_read && (id_ex.rd != '0) &&
                   ((id_ex.rd == id_rs1) || (id_ex.rd == id_rs2));

    // EX operand forwarding, newest producer first.
    always_comb begin
        fwd_a = id_ex.rs1_val;
        fwd_b = id_ex.rs2_val;
        if (ex_mem.reg_write && (ex_mem.rd != '0) && (ex_mem.rd == id_ex.rs1))
            fwd_a = ex_mem.alu_result;
        else if (mem_wb.reg_write && (mem_wb.rd != '0) && (mem_wb.rd == id_ex.rs1))
            fwd_a = mem_wb.wb_data;
        if (ex_mem.reg_write && (ex_mem.rd != '0) && (ex_mem.rd == id_ex.rs2))
            fwd_b = ex_mem.alu_result;
        else if (mem_wb.reg_write && (mem_wb.rd != '0) && (mem_wb.rd == id_ex.rs2))
            fwd_b = mem_wb.wb_data;
    end

    assign alu_b         = id_ex.use_imm ? id_ex.imm : fwd_b;
    assign taken         = id_ex.branch && (fwd_a == fwd_b);
    assign branch_target = id_ex.pc + id_ex.imm;

    // Next pipeline state; a taken branch flushes and overrides any stall.
    always_comb begin
        if_id_next      = '0;
        if_id_next.pc   = pc;
        if_id_next.inst = fetch_inst;
        id_ex_next      = dec;
        pc_next         = pc + XLEN'(4);
        pc_en           = 1'b1;
        if (taken) begin
            if_id_next = '0;
            id_ex_next = '0;
            pc_next    = branch_target;
        end else if (stall) begin
            if_id_next = if_id;
            id_ex_next = '0;
            pc_en      = 1'b0;
        end

        ex_mem_next            = '0;
        ex_mem_next.alu_result = alu_result;
        ex_mem_next.store_data = fwd_b;
        ex_mem_next.rd         = id_ex.rd;
        ex_mem_next.reg_write  = id_ex.reg_write;
        ex_mem_next.mem_read   = id_ex.mem_read;
        ex_mem_next.mem_write  = id_ex.mem_write;

        mem_wb_next           = '0;
        mem_wb_next.wb_data   = ex_mem.mem_read ? dmem_rdata : ex_mem.alu_result;
        mem_wb_next.rd        = ex_mem.rd;
        mem_wb_next.reg_write = ex_mem.reg_write;
    end

    // Pipeline registers; reset leaves bubbles everywhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id  <= '0;
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            if_id  <= if_id_next;
            id_ex  <= id_ex_next;
            ex_mem <= ex_mem_next;
            mem_wb <= mem_wb_next;
        end
    end

endmodule

// File: tb/tb_pipeline_cpu_top.sv
// Scoreboard bench for pipeline_cpu_top: programs preloaded hierarchically, results checked in state.
module tb_pipeline_cpu_top;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_SD = 7'b0100011;
    localparam logic [6:0] OPC_BR = 7'b1100011;

    localparam int K_REG   = 0;
    localparam int K_MEM64 = 1;
    localparam int K_PC    = 2;
    localparam int K_BYTE  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipeline_cpu_top #(.IMEM_WORDS(64), .DMEM_BYTES(256)) dut (
        .clk(clk),
        .rst(rst)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [63:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] prog[$];
    int          n_pass = 0;
    int          n_chk  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input int rd, input int rs1, input int rs2);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), OPC_R};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input int rd, input int rs1, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im, 5'(rs1), f3, 5'(rd), op};
    endfunction

    function automatic logic [31:0] f_add(input int rd, input int a, input int b);
        return enc_r(7'b0000000, 3'b000, rd, a, b);
    endfunction
    function automatic logic [31:0] f_sub(input int rd, input int a, input int b);
        return enc_r(7'b0100000, 3'b000, rd, a, b);
    endfunction
    function automatic logic [31:0] f_and(input int rd, input int a, input int b);
        return enc_r(7'b0000000, 3'b111, rd, a, b);
    endfunction
    function automatic logic [31:0] f_or(input int rd, input int a, input int b);
        return enc_r(7'b0000000, 3'b110, rd, a, b);
    endfunction
    function automatic logic [31:0] f_slt(input int rd, input int a, input int b);
        return enc_r(7'b0000000, 3'b010, rd, a, b);
    endfunction
    function automatic logic [31:0] f_addi(input int rd, input int rs1, input int imm);
        return enc_i(OPC_I, 3'b000, rd, rs1, imm);
    endfunction
    function automatic logic [31:0] f_ld(input int rd, input int imm, input int rs1);
        return enc_i(OPC_LD, 3'b011, rd, rs1, imm);
    endfunction
    function automatic logic [31:0] f_sd(input int rs2, input int imm, input int rs1);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b011, im[4:0], OPC_SD};
    endfunction
    function automatic logic [31:0] f_beq(input int rs1, input int rs2, input int imm);
        logic [12:0] im;
        im = 13'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'b000, im[4:1], im[11], OPC_BR};
    endfunction

    task automatic expect_val(input string tag, input int kind, input int idx, input logic [63:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    // Pop every pending expectation and compare it with DUT state.
    task automatic drain();
        exp_t        e;
        logic [63:0] got;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = '0;
            case (e.kind)
                K_REG:   got = dut.REGISTERS.register_bank[e.idx];
                K_MEM64: for (int k = 0; k < 8; k++) got[8*k +: 8] = dut.DATA_MEM.memory[e.idx + k];
                K_PC:    got = dut.PC.OUT;
                default: got = 64'(dut.DATA_MEM.memory[e.idx]);
            endcase
            check(e.tag, got, e.val);
        end
    endtask

    // Reset for three edges, loading prog into instruction memory under reset.
    task automatic boot();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 64; i++) dut.INST_MEM.memory[i] = '0;
        for (int i = 0; i < prog.size(); i++) dut.INST_MEM.memory[i] = prog[i];
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_and_drain(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dut.DATA_MEM.memory[i] = '0;

        // Load / add / store with a load-use stall
        dut.DATA_MEM.memory[0] = 8'h0A;
        dut.DATA_MEM.memory[8] = 8'h14;
        prog = '{f_ld(1, 0, 0), f_ld(2, 8, 0), f_add(3, 1, 2), f_sd(3, 16, 0)};
        boot();
        expect_val("ldst_stall_pc", K_PC, 0, 64'd12);
        run_and_drain(4);
        expect_val("ldst_x1", K_REG, 1, 64'h0A);
        expect_val("ldst_x2", K_REG, 2, 64'h14);
        expect_val("ldst_x3", K_REG, 3, 64'h1E);
        expect_val("ldst_mem16", K_MEM64, 16, 64'h1E);
        run_and_drain(20);

        // Reset clears PC and registers, leaves data memory alone
        @(negedge clk);
        rst = 1'b1;
        dut.DATA_MEM.memory[100] = 8'h5A;
        repeat (3) @(negedge clk);
        expect_val("rst_pc", K_PC, 0, 64'd0);
        expect_val("rst_x1", K_REG, 1, 64'd0);
        expect_val("rst_x2", K_REG, 2, 64'd0);
        expect_val("rst_x3", K_REG, 3, 64'd0);
        expect_val("rst_byte100", K_BYTE, 100, 64'h5A);
        expect_val("rst_mem16", K_MEM64, 16, 64'h1E);
        drain();

        // Back-to-back ALU dependencies
        prog = '{f_addi(1, 0, 5), f_addi(2, 1, -7), f_sub(3, 1, 2), f_and(4, 3, 1)};
        boot();
        expect_val("chain_x1", K_REG, 1, 64'd5);
        expect_val("chain_x2", K_REG, 2, 64'hFFFF_FFFF_FFFF_FFFE);
        expect_val("chain_x3", K_REG, 3, 64'd7);
        expect_val("chain_x4", K_REG, 4, 64'd5);
        run_and_drain(20);

        // Taken branch flushes the shadow instruction
        prog = '{f_addi(1, 0, 1), f_beq(1, 1, 8), f_addi(2, 0, 9), f_addi(3, 0, 3)};
        boot();
        expect_val("br_taken_pc", K_PC, 0, 64'd12);
        run_and_drain(4);
        expect_val("br_taken_x1", K_REG, 1, 64'd1);
        expect_val("br_taken_x2", K_REG, 2, 64'd0);
        expect_val("br_taken_x3", K_REG, 3, 64'd3);
        run_and_drain(20);

        // Not-taken branch falls through with no bubble
        prog = '{f_addi(1, 0, 1), f_beq(0, 1, 8), f_addi(2, 0, 9), f_addi(3, 0, 3)};
        boot();
        expect_val("br_nt_pc", K_PC, 0, 64'd24);
        run_and_drain(6);
        expect_val("br_nt_x1", K_REG, 1, 64'd1);
        expect_val("br_nt_x2", K_REG, 2, 64'd9);
        expect_val("br_nt_x3", K_REG, 3, 64'd3);
        run_and_drain(20);

        // x0 is never written nor forwarded
        prog = '{f_addi(0, 0, 7), f_add(5, 0, 0)};
        boot();
        expect_val("x0_x0", K_REG, 0, 64'd0);
        expect_val("x0_x5", K_REG, 5, 64'd0);
        run_and_drain(20);

        // Signed slt, or, sub and forwarding priority on repeated rd
        prog = '{f_addi(1, 0, -3), f_addi(2, 0, 2), f_slt(3, 1, 2), f_slt(4, 2, 1),
                 f_or(5, 1, 2), f_sub(6, 1, 2),
                 f_addi(7, 0, 1), f_addi(7, 7, 1), f_addi(7, 7, 1)};
        boot();
        expect_val("slt_x3", K_REG, 3, 64'd1);
        expect_val("slt_x4", K_REG, 4, 64'd0);
        expect_val("or_x5", K_REG, 5, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_val("sub_x6", K_REG, 6, 64'hFFFF_FFFF_FFFF_FFFB);
        expect_val("fwd_prio_x7", K_REG, 7, 64'd3);
        run_and_drain(25);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
